decode_wb_pipe: RTL and testbench



---
 rtl/y86_defs.sv | 88 ++++++++
 rtl/regfile_y86.sv | 55 +++++
 rtl/decode_wb_pipe.sv | 131 +++++++++++++
 tb/tb_decode_wb_pipe.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_defs.sv
// Shared Y86-64 definitions: instruction codes, register IDs, ALU function codes
// and the decode helper that maps an instruction to its register sources/destinations.
package y86_defs;

    typedef enum logic [3:0] {
        I_HALT   = 4'h0,
        I_NOP    = 4'h1,
        I_RRMOVQ = 4'h2,
        I_IRMOVQ = 4'h3,
        I_RMMOVQ = 4'h4,
        I_MRMOVQ = 4'h5,
        I_OPQ    = 4'h6,
        I_JXX    = 4'h7,
        I_CALL   = 4'h8,
        I_RET    = 4'h9,
        I_PUSHQ  = 4'hA,
        I_POPQ   = 4'hB
    } icode_t;

    typedef enum logic [3:0] {
        ALU_ADD = 4'h0,
        ALU_SUB = 4'h1,
        ALU_AND = 4'h2,
        ALU_XOR = 4'h3
    } alu_fun_t;

    localparam logic [3:0] RSP_ID    = 4'h4;
    localparam logic [3:0] RNONE     = 4'hF;
    localparam logic [3:0] NOP_ICODE = 4'h1;

    typedef struct packed {
        logic [3:0] src_a;
        logic [3:0] src_b;
        logic [3:0] dst_e;
        logic [3:0] dst_m;
    } reg_ids_t;

    // Unknown icodes fall through to "no register" everywhere.
    function automatic reg_ids_t decode_reg_ids(input logic [3:0] icode,
                                                input logic [3:0] r_a,
                                                input logic [3:0] r_b);
        reg_ids_t ids;
        ids = '{src_a: RNONE, src_b: RNONE, dst_e: RNONE, dst_m: RNONE};
        case (icode)
            I_RRMOVQ: begin
                ids.src_a = r_a;
                ids.dst_e = r_b;
            end
            I_IRMOVQ: ids.dst_e = r_b;
            I_RMMOVQ: begin
                ids.src_a = r_a;
                ids.src_b = r_b;
            end
            I_MRMOVQ: begin
                ids.src_b = r_b;
                ids.dst_m = r_a;
            end
            I_OPQ: begin
                ids.src_a = r_a;
                ids.src_b = r_b;
                ids.dst_e = r_b;
            end
            I_CALL: begin
                ids.src_b = RSP_ID;
                ids.dst_e = RSP_ID;
            end
            I_RET: begin
                ids.src_a = RSP_ID;
                ids.src_b = RSP_ID;
                ids.dst_e = RSP_ID;
            end
            I_PUSHQ: begin
                ids.src_a = r_a;
                ids.src_b = RSP_ID;
                ids.dst_e = RSP_ID;
            end
            I_POPQ: begin
                ids.src_a = RSP_ID;
                ids.src_b = RSP_ID;
                ids.dst_e = RSP_ID;
                ids.dst_m = r_a;
            end
            default: ;
        endcase
        return ids;
    endfunction

endpackage

// File: rtl/regfile_y86.sv
// Fifteen-entry Y86-64 register file: two combinational read ports, two write ports
// (M port wins when both target the same register), synchronous clear.
module regfile_y86
    import y86_defs::*;
#(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        rd_a_id,
    input  logic [3:0]        rd_b_id,
    output logic [DATA_W-1:0] rd_a_val,
    output logic [DATA_W-1:0] rd_b_val,
    input  logic [3:0]        wr_e_id,
    input  logic [DATA_W-1:0] wr_e_val,
    input  logic [3:0]        wr_m_id,
    input  logic [DATA_W-1:0] wr_m_val
);

    localparam int NREGS = 15;

    logic [DATA_W-1:0] regs_reg  [NREGS];
    logic [DATA_W-1:0] regs_next [NREGS];

    // RNONE (15) never equals any index here, so it can never write.
    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg_next
            assign regs_next[gi] = (wr_m_id == 4'(gi)) ? wr_m_val :
                                   (wr_e_id == 4'(gi)) ? wr_e_val :
                                                         regs_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < NREGS; i++) begin
            if (reset) begin
                regs_reg[i] <= '0;
            end else begin
                regs_reg[i] <= regs_next[i];
            end
        end
    end

    always_comb begin
        rd_a_val = '0;
        rd_b_val = '0;
        if (rd_a_id != RNONE) begin
            rd_a_val = regs_reg[rd_a_id];
        end
        if (rd_b_id != RNONE) begin
            rd_b_val = regs_reg[rd_b_id];
        end
    end

endmodule

// File: rtl/decode_wb_pipe.sv
// Y86-64 decode / write-back stage: register selection, forwarding from E/M/W,
// the register file, and the E pipeline register feeding execute.
module decode_wb_pipe
    import y86_defs::*;
#(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        D_icode,
    input  logic [3:0]        D_ifun,
    input  logic [3:0]        D_rA,
    input  logic [3:0]        D_rB,
    input  logic [DATA_W-1:0] D_valC,
    input  logic [DATA_W-1:0] D_valP,
    input  logic              E_bubble,
    input  logic [3:0]        e_dstE,
    input  logic [DATA_W-1:0] e_valE,
    input  logic [3:0]        M_dstE,
    input  logic [DATA_W-1:0] M_valE,
    input  logic [3:0]        M_dstM,
    input  logic [DATA_W-1:0] m_valM,
    input  logic [3:0]        W_dstE,
    input  logic [DATA_W-1:0] W_valE,
    input  logic [3:0]        W_dstM,
    input  logic [DATA_W-1:0] W_valM,
    output logic [3:0]        d_srcA,
    output logic [3:0]        d_srcB,
    output logic [3:0]        E_icode,
    output logic [3:0]        E_ifun,
    output logic [DATA_W-1:0] E_valA,
    output logic [DATA_W-1:0] E_valB,
    output logic [DATA_W-1:0] E_valC,
    output logic [3:0]        E_dstE,
    output logic [3:0]        E_dstM,
    output logic [3:0]        E_srcA,
    output logic [3:0]        E_srcB
);

    reg_ids_t          ids;
    logic [DATA_W-1:0] rf_a_val;
    logic [DATA_W-1:0] rf_b_val;
    logic [DATA_W-1:0] d_val_a;
    logic [DATA_W-1:0] d_val_b;

    assign ids    = decode_reg_ids(D_icode, D_rA, D_rB);
    assign d_srcA = ids.src_a;
    assign d_srcB = ids.src_b;

    regfile_y86 #(.DATA_W(DATA_W)) u_regfile (
        .clk      (clk),
        .reset    (reset),
        .rd_a_id  (ids.src_a),
        .rd_b_id  (ids.src_b),
        .rd_a_val (rf_a_val),
        .rd_b_val (rf_b_val),
        .wr_e_id  (W_dstE),
        .wr_e_val (W_valE),
        .wr_m_id  (W_dstM),
        .wr_m_val (W_valM)
    );

    // Youngest producer first; a RNONE source is filtered out before any compare,
    // so it cannot alias a RNONE destination.
    function automatic logic [DATA_W-1:0] forward(input logic [3:0]        src,
                                                  input logic [DATA_W-1:0] rf_val);
        logic [DATA_W-1:0] val;
        if (src == RNONE)        val = '0;
        else if (src == e_dstE)  val = e_valE;
        else if (src == M_dstM)  val = m_valM;
        else if (src == M_dstE)  val = M_valE;
        else if (src == W_dstM)  val = W_valM;
        else if (src == W_dstE)  val = W_valE;
        else                     val = rf_val;
        return val;
    endfunction

    always_comb begin
        d_val_a = forward(ids.src_a, rf_a_val);
        // call and jXX carry valP down the valA path instead of a register.
        if (D_icode == I_CALL || D_icode == I_JXX) begin
            d_val_a = D_valP;
        end
        d_val_b = forward(ids.src_b, rf_b_val);
    end

    logic [3:0]        e_icode_reg;
    logic [3:0]        e_ifun_reg;
    logic [DATA_W-1:0] e_val_a_reg;
    logic [DATA_W-1:0] e_val_b_reg;
    logic [DATA_W-1:0] e_val_c_reg;
    logic [3:0]        e_dst_e_reg;
    logic [3:0]        e_dst_m_reg;
    logic [3:0]        e_src_a_reg;
    logic [3:0]        e_src_b_reg;

    always_ff @(posedge clk) begin
        if (reset || E_bubble) begin
            e_icode_reg <= NOP_ICODE;
            e_ifun_reg  <= 4'h0;
            e_val_a_reg <= '0;
            e_val_b_reg <= '0;
            e_val_c_reg <= '0;
            e_dst_e_reg <= RNONE;
            e_dst_m_reg <= RNONE;
            e_src_a_reg <= RNONE;
            e_src_b_reg <= RNONE;
        end else begin
            e_icode_reg <= D_icode;
            e_ifun_reg  <= D_ifun;
            e_val_a_reg <= d_val_a;
            e_val_b_reg <= d_val_b;
            e_val_c_reg <= D_valC;
            e_dst_e_reg <= ids.dst_e;
            e_dst_m_reg <= ids.dst_m;
            e_src_a_reg <= ids.src_a;
            e_src_b_reg <= ids.src_b;
        end
    end

    assign E_icode = e_icode_reg;
    assign E_ifun  = e_ifun_reg;
    assign E_valA  = e_val_a_reg;
    assign E_valB  = e_val_b_reg;
    assign E_valC  = e_val_c_reg;
    assign E_dstE  = e_dst_e_reg;
    assign E_dstM  = e_dst_m_reg;
    assign E_srcA  = e_src_a_reg;
    assign E_srcB  = e_src_b_reg;

endmodule

// File: tb/tb_decode_wb_pipe.sv
// Scoreboard bench for decode_wb_pipe: an independent register-file/forwarding model
// queues the expected E contents per driven cycle and checks them after the edge.
module tb_decode_wb_pipe;

    localparam logic [3:0] F = 4'hF;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  D_icode, D_ifun, D_rA, D_rB;
    logic [63:0] D_valC, D_valP;
    logic        E_bubble;
    logic [3:0]  e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
    logic [63:0] e_valE, M_valE, m_valM, W_valE, W_valM;
    logic [3:0]  d_srcA, d_srcB;
    logic [3:0]  E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB;
    logic [63:0] E_valA, E_valB, E_valC;

    decode_wb_pipe #(.DATA_W(64)) dut (
        .clk(clk), .reset(reset),
        .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
        .D_valC(D_valC), .D_valP(D_valP), .E_bubble(E_bubble),
        .e_dstE(e_dstE), .e_valE(e_valE),
        .M_dstE(M_dstE), .M_valE(M_valE), .M_dstM(M_dstM), .m_valM(m_valM),
        .W_dstE(W_dstE), .W_valE(W_valE), .W_dstM(W_dstM), .W_valM(W_valM),
        .d_srcA(d_srcA), .d_srcB(d_srcB),
        .E_icode(E_icode), .E_ifun(E_ifun),
        .E_valA(E_valA), .E_valB(E_valB), .E_valC(E_valC),
        .E_dstE(E_dstE), .E_dstM(E_dstM), .E_srcA(E_srcA), .E_srcB(E_srcB)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [63:0] val_a;
        logic [63:0] val_b;
        logic [63:0] val_c;
        logic [3:0]  dst_e;
        logic [3:0]  dst_m;
        logic [3:0]  src_a;
        logic [3:0]  src_b;
    } e_exp_t;

    e_exp_t      exp_q[$];
    logic [63:0] rf_model [16];
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] m_src_a(input logic [3:0] ic, input logic [3:0] ra);
        if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) return ra;
        if (ic inside {4'h9, 4'hB})             return 4'h4;
        return F;
    endfunction

    function automatic logic [3:0] m_src_b(input logic [3:0] ic, input logic [3:0] rb);
        if (ic inside {4'h4, 4'h5, 4'h6})       return rb;
        if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
        return F;
    endfunction

    function automatic logic [3:0] m_dst_e(input logic [3:0] ic, input logic [3:0] rb);
        if (ic inside {4'h2, 4'h3, 4'h6})       return rb;
        if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
        return F;
    endfunction

    function automatic logic [3:0] m_dst_m(input logic [3:0] ic, input logic [3:0] ra);
        return (ic inside {4'h5, 4'hB}) ? ra : F;
    endfunction

    function automatic logic [63:0] m_operand(input logic [3:0] src);
        if (src == F)      return 64'h0;
        if (src == e_dstE) return e_valE;
        if (src == M_dstM) return m_valM;
        if (src == M_dstE) return M_valE;
        if (src == W_dstM) return W_valM;
        if (src == W_dstE) return W_valE;
        return rf_model[src];
    endfunction

    task automatic idle_inputs();
        reset = 1'b0; E_bubble = 1'b0;
        D_icode = 4'h1; D_ifun = 4'h0; D_rA = F; D_rB = F;
        D_valC = 64'h0; D_valP = 64'h0;
        e_dstE = F; M_dstE = F; M_dstM = F; W_dstE = F; W_dstM = F;
        e_valE = 64'h0; M_valE = 64'h0; m_valM = 64'h0; W_valE = 64'h0; W_valM = 64'h0;
    endtask

    // Called at a falling edge with inputs already driven; consumes one clock.
    task automatic step(input string tag);
        e_exp_t e;
        e_exp_t got;
        logic [3:0] sa, sb;
        #1;
        sa = m_src_a(D_icode, D_rA);
        sb = m_src_b(D_icode, D_rB);
        check({tag, ".d_srcA"}, 64'(d_srcA), 64'(sa));
        check({tag, ".d_srcB"}, 64'(d_srcB), 64'(sb));
        if (reset || E_bubble) begin
            e = '{icode: 4'h1, ifun: 4'h0, val_a: 64'h0, val_b: 64'h0, val_c: 64'h0,
                  dst_e: F, dst_m: F, src_a: F, src_b: F};
        end else begin
            e.icode = D_icode;
            e.ifun  = D_ifun;
            e.val_a = (D_icode inside {4'h7, 4'h8}) ? D_valP : m_operand(sa);
            e.val_b = m_operand(sb);
            e.val_c = D_valC;
            e.dst_e = m_dst_e(D_icode, D_rB);
            e.dst_m = m_dst_m(D_icode, D_rA);
            e.src_a = sa;
            e.src_b = sb;
        end
        exp_q.push_back(e);
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 16; i++) rf_model[i] = 64'h0;
        end else begin
            if (W_dstE != F) rf_model[W_dstE] = W_valE;
            if (W_dstM != F) rf_model[W_dstM] = W_valM;
        end
        #1;
        got = exp_q.pop_front();
        check({tag, ".icode"}, 64'(E_icode), 64'(got.icode));
        check({tag, ".ifun"},  64'(E_ifun),  64'(got.ifun));
        check({tag, ".valA"},  E_valA,       got.val_a);
        check({tag, ".valB"},  E_valB,       got.val_b);
        check({tag, ".valC"},  E_valC,       got.val_c);
        check({tag, ".dstE"},  64'(E_dstE),  64'(got.dst_e));
        check({tag, ".dstM"},  64'(E_dstM),  64'(got.dst_m));
        check({tag, ".srcA"},  64'(E_srcA),  64'(got.src_a));
        check({tag, ".srcB"},  64'(E_srcB),  64'(got.src_b));
        $display("txn %-10s icode=%h valA=%h valB=%h dstE=%h dstM=%h",
                 tag, E_icode, E_valA, E_valB, E_dstE, E_dstM);
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rf_model[i] = 64'h0;
        idle_inputs();
        reset = 1'b1;
        @(negedge clk);
        step("reset0");
        reset = 1'b1; D_icode = 4'h6; D_rA = 4'h1; D_rB = 4'h2;
        step("reset1");

        // Register file round trip: W forwarding in the write cycle, RF read after.
        idle_inputs();
        D_icode = 4'h6; D_rA = 4'h3; D_rB = 4'h7; W_dstE = 4'h3; W_valE = 64'h55;
        step("rt_wfwd");
        W_dstE = F; W_valE = 64'h0;
        step("rt_rf");

        // Forwarding priority: e beats M beats W.
        idle_inputs();
        D_icode = 4'h2; D_rA = 4'h2; D_rB = 4'h6;
        e_dstE = 4'h2; e_valE = 64'h11; M_dstM = 4'h2; m_valM = 64'h22;
        W_dstE = 4'h2; W_valE = 64'h33;
        step("prio_e");
        e_dstE = F;
        step("prio_m");
        M_dstM = F; M_dstE = 4'h2; M_valE = 64'h44; W_dstM = 4'h2; W_valM = 64'h66;
        step("prio_me");
        M_dstE = F;
        step("prio_wm");

        // popq %rsp collision: valM wins, then read reg 4 via rrmovq.
        idle_inputs();
        W_dstE = 4'h4; W_valE = 64'h108; W_dstM = 4'h4; W_valM = 64'hABC;
        step("pop_wr");
        idle_inputs();
        D_icode = 4'h2; D_rA = 4'h4; D_rB = 4'h0;
        step("pop_rd");

        // call: set rsp=0x200, then valA=valP, valB=rsp.
        idle_inputs();
        W_dstE = 4'h4; W_valE = 64'h200;
        step("call_wr");
        idle_inputs();
        D_icode = 4'h8; D_valP = 64'h40; D_valC = 64'h1000;
        step("call");

        // Bubble then the same addq loads.
        idle_inputs();
        D_icode = 4'h6; D_ifun = 4'h0; D_rA = 4'h3; D_rB = 4'h4; E_bubble = 1'b1;
        step("bubble");
        E_bubble = 1'b0;
        step("addq");

        // Unlisted icode and RNONE source against an RNONE destination.
        idle_inputs();
        D_icode = 4'hC; D_rA = 4'h3; D_rB = 4'h4; e_dstE = F; e_valE = 64'hDEAD;
        step("bad_icode");

        // Reset mid-stream discards the W write and clears everything.
        idle_inputs();
        W_dstE = 4'h5; W_valE = 64'h99;
        step("r5_wr");
        W_valE = 64'h77; reset = 1'b1; E_bubble = 1'b0;
        D_icode = 4'h6; D_rA = 4'h5; D_rB = 4'h3;
        step("rst_mid");
        idle_inputs();
        D_icode = 4'h2; D_rA = 4'h5; D_rB = 4'h4;
        step("r5_rd");
        D_rA = 4'h3;
        step("r3_rd");

        // Random traffic against the model.
        for (int n = 0; n < 48; n++) begin
            idle_inputs();
            D_icode  = 4'($urandom_range(0, 15));
            D_ifun   = 4'($urandom_range(0, 15));
            D_rA     = 4'($urandom_range(0, 15));
            D_rB     = 4'($urandom_range(0, 15));
            D_valC   = {$urandom, $urandom};
            D_valP   = {$urandom, $urandom};
            E_bubble = ($urandom_range(0, 7) == 0);
            e_dstE   = 4'($urandom_range(0, 15)); e_valE = {$urandom, $urandom};
            M_dstE   = 4'($urandom_range(0, 15)); M_valE = {$urandom, $urandom};
            M_dstM   = 4'($urandom_range(0, 15)); m_valM = {$urandom, $urandom};
            W_dstE   = 4'($urandom_range(0, 15)); W_valE = {$urandom, $urandom};
            W_dstM   = 4'($urandom_range(0, 15)); W_valM = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) e_dstE = F;
            if ($urandom_range(0, 1) == 1) M_dstM = F;
            if ($urandom_range(0, 1) == 1) M_dstE = F;
            step("rand");
        end

        check("queue_empty", 64'(exp_q.size()), 64'h0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
